// File: rtl/vid_hcount.sv
`default_nettype none
// ============================================================================
// Module      : vid_hcount
// Description : Horizontal half-line counter with period shadow and registered
//               blank/sync event generation for the video timing chain.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_hcount #(
    parameter int HSW_W = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             en,
    input  logic [9:0]       hp,
    input  logic [10:0]      hbb,
    input  logic [10:0]      hbe,
    input  logic [10:0]      hs,
    input  logic [HSW_W-1:0] hsw,
    output logic [10:0]      hcnt,
    output logic             line_end,
    output logic             hblank,
    output logic             hsync,
    output logic             hgt_hbb
);

    localparam logic [HSW_W-1:0] c_sw_one = HSW_W'(1);

    logic [9:0]       r_cnt;
    logic             r_half;
    logic [9:0]       r_hp_sh;
    logic             r_line_end;
    logic             r_hblank;
    logic             r_hsync;
    logic [HSW_W-1:0] r_sw_cnt;
    logic             r_hgt_hbb;

    logic [10:0]      w_pos;
    logic             w_wrap;
    logic             w_hs_hit;

    assign w_pos    = {r_half, r_cnt};
    assign w_wrap   = (r_cnt == r_hp_sh);
    assign w_hs_hit = (w_pos == hs) && (hsw != '0);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_half     <= 1'b0;
            r_hp_sh    <= hp;
            r_line_end <= 1'b0;
            r_hblank   <= 1'b1;
            r_hsync    <= 1'b0;
            r_sw_cnt   <= '0;
            r_hgt_hbb  <= 1'b0;
        end else begin
            r_line_end <= 1'b0;
            r_hgt_hbb  <= (w_pos > hbb);
            if (en) begin
                // The period shadow only reloads at the full-line wrap, so a
                // mid-line hp change cannot strand cnt above the period.
                if (w_wrap) begin
                    r_cnt  <= '0;
                    r_half <= ~r_half;
                    if (r_half) begin
                        r_line_end <= 1'b1;
                        r_hp_sh    <= hp;
                    end
                end else begin
                    r_cnt <= r_cnt + 10'd1;
                end

                // Blank set takes priority when begin and end coincide.
                if (w_pos == hbb) begin
                    r_hblank <= 1'b1;
                end else if (w_pos == hbe) begin
                    r_hblank <= 1'b0;
                end

                if (w_hs_hit) begin
                    r_hsync  <= 1'b1;
                    r_sw_cnt <= hsw - c_sw_one;
                end else if (r_hsync) begin
                    if (r_sw_cnt == '0) begin
                        r_hsync <= 1'b0;
                    end else begin
                        r_sw_cnt <= r_sw_cnt - c_sw_one;
                    end
                end
            end
        end
    end

    assign hcnt     = w_pos;
    assign line_end = r_line_end;
    assign hblank   = r_hblank;
    assign hsync    = r_hsync;
    assign hgt_hbb  = r_hgt_hbb;

endmodule
`default_nettype wire

// File: tb/tb_vid_hcount.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_hcount
// Description : Directed self-checking bench for the horizontal counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_hcount;

    localparam int HSW_W = 8;

    logic             sys_clk;
    logic             reset;
    logic             en;
    logic [9:0]       hp;
    logic [10:0]      hbb;
    logic [10:0]      hbe;
    logic [10:0]      hs;
    logic [HSW_W-1:0] hsw;
    logic [10:0]      hcnt;
    logic             line_end;
    logic             hblank;
    logic             hsync;
    logic             hgt_hbb;

    int n_checks = 0;
    int n_err    = 0;

    vid_hcount #(.HSW_W(HSW_W)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .en       (en),
        .hp       (hp),
        .hbb      (hbb),
        .hbe      (hbe),
        .hs       (hs),
        .hsw      (hsw),
        .hcnt     (hcnt),
        .line_end (line_end),
        .hblank   (hblank),
        .hsync    (hsync),
        .hgt_hbb  (hgt_hbb)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [9:0] period);
        hp    = period;
        reset = 1'b1;
        en    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int le_cnt;
        int le_first;
        int le_second;
        int hs_cnt;
        logic [10:0] exp_pos;

        reset = 1'b0; en = 1'b0; hp = 10'd3;
        hbb = 11'h7FF; hbe = 11'h7FF; hs = 11'h7FF; hsw = '0;

        // ---- reset state
        do_reset(10'd3);
        chk("rst_hcnt",     32'(hcnt),     32'h000);
        chk("rst_line_end", 32'(line_end), 32'd0);
        chk("rst_hblank",   32'(hblank),   32'd1);
        chk("rst_hsync",    32'(hsync),    32'd0);
        chk("rst_hgt_hbb",  32'(hgt_hbb),  32'd0);

        // ---- hp=3, en held high: 1,2,3,400,401,402,403,000
        en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_pos = {((i / 4) % 2 == 1), 10'(i % 4)};
            chk("seq_hcnt", 32'(hcnt), 32'(exp_pos));
            chk("seq_line_end", 32'(line_end), (i == 8) ? 32'd1 : 32'd0);
        end

        // ---- hp=3, en toggling: advance only on en, one line_end per 16 clocks
        le_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            en = (k % 2 == 0);
            tick();
            exp_pos = {(((k / 2 + 1) / 4) % 2 == 1), 10'((k / 2 + 1) % 4)};
            chk("tog_hcnt", 32'(hcnt), 32'(exp_pos));
            if (line_end) le_cnt++;
        end
        chk("tog_line_end_count", 32'(le_cnt), 32'd1);
        en = 1'b0;

        // ---- blank: hp=7, hbb=005, hbe=402
        do_reset(10'd7);
        hbb = 11'h005; hbe = 11'h402;
        en = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            tick();
            chk("blank_level", 32'(hblank), (i >= 11 && i <= 21) ? 32'd0 : 32'd1);
        end
        chk("blank_pos22", 32'(hcnt), 32'h006);
        for (int i = 23; i <= 27; i++) tick();
        chk("blank_low_403", 32'(hblank), 32'd0);
        chk("blank_pos403", 32'(hcnt), 32'h403);
        hbb = 11'h005; hbe = 11'h005;
        for (int i = 28; i <= 37; i++) tick();
        chk("blank_eq_pos5", 32'(hcnt), 32'h005);
        chk("blank_eq_before", 32'(hblank), 32'd0);
        tick();
        chk("blank_eq_setwins", 32'(hblank), 32'd1);

        // ---- sync: hs=001, hsw=3, hp=9
        hbb = 11'h7FF; hbe = 11'h7FF;
        do_reset(10'd9);
        hs = 11'h001; hsw = 8'd3;
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("sync_level", 32'(hsync), (i >= 2 && i <= 4) ? 32'd1 : 32'd0);
        end
        hsw = '0;
        hs_cnt = 0;
        for (int i = 7; i <= 26; i++) begin
            tick();
            if (hsync) hs_cnt++;
        end
        chk("sync_disabled", 32'(hs_cnt), 32'd0);
        hs = 11'h7FF;

        // ---- period change mid-line: 9 -> 4 at hcnt=003
        do_reset(10'd9);
        en = 1'b1;
        le_first = 0; le_second = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 3) begin
                chk("hp_chg_at3", 32'(hcnt), 32'h003);
                hp = 10'd4;
            end
            if (i == 19) chk("hp_chg_409", 32'(hcnt), 32'h409);
            if (i == 25) chk("hp_chg_400", 32'(hcnt), 32'h400);
            if (line_end) begin
                if (le_first == 0) le_first = i;
                else if (le_second == 0) le_second = i;
            end
        end
        chk("hp_chg_le_first",  32'(le_first),  32'd20);
        chk("hp_chg_le_second", 32'(le_second), 32'd30);

        // ---- reset mid-line with hsync active, then hp=0
        do_reset(10'd9);
        hs = 11'h405; hsw = 8'd4;
        en = 1'b1;
        for (int i = 1; i <= 16; i++) tick();
        chk("pre_rst_hcnt",  32'(hcnt),  32'h406);
        chk("pre_rst_hsync", 32'(hsync), 32'd1);
        hp = 10'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_hcnt",     32'(hcnt),     32'h000);
        chk("mid_rst_hsync",    32'(hsync),    32'd0);
        chk("mid_rst_hblank",   32'(hblank),   32'd1);
        chk("mid_rst_line_end", 32'(line_end), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("hp0_hcnt", 32'(hcnt), (i % 2 == 1) ? 32'h400 : 32'h000);
            chk("hp0_line_end", 32'(line_end), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // ---- hgt_hbb updates without en
        tick();
        en = 1'b0;
        chk("gt_hold_pos", 32'(hcnt), 32'h400);
        hbb = 11'h3FF;
        tick();
        chk("gt_above", 32'(hgt_hbb), 32'd1);
        hbb = 11'h400;
        tick();
        chk("gt_equal", 32'(hgt_hbb), 32'd0);
        hbb = 11'h401;
        tick();
        chk("gt_below", 32'(hgt_hbb), 32'd0);
        chk("gt_pos_held", 32'(hcnt), 32'h400);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
